// File: rtl/fir_window_queue.sv
// Circular sample queue ahead of the FIR MAC: decimates the input stream and replays the
// newest WIN_LEN stored samples oldest-first as a burst after every stored sample once primed.
module fir_window_queue #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned WIN_LEN = 1021,
    parameter int unsigned DECIM   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] new_smpl,
    input  logic              valid_rise,
    input  logic              flush,
    output logic [DATA_W-1:0] smpl_out,
    output logic              smpl_vld,
    output logic              smpl_first,
    output logic              smpl_last,
    output logic              sequencing,
    output logic              primed,
    output logic              overrun
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned PH_W  = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int unsigned CNT_W = $clog2(WIN_LEN + 1);

    localparam logic [1:0] S_FILL  = 2'd0;
    localparam logic [1:0] S_READY = 2'd1;
    localparam logic [1:0] S_SEQ   = 2'd2;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [CNT_W-1:0]  fill_cnt_q, fill_cnt_d;
    logic              pend_q, pend_d;
    logic [ADDR_W-1:0] pend_base_q, pend_base_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [CNT_W-1:0]  rd_idx_q, rd_idx_d;
    logic              overrun_q, overrun_d;
    logic [DATA_W-1:0] smpl_out_q, smpl_out_d;
    logic              smpl_vld_q, smpl_vld_d;
    logic              smpl_first_q, smpl_first_d;
    logic              smpl_last_q, smpl_last_d;
    logic              sequencing_q, sequencing_d;
    logic              primed_q, primed_d;

    logic              wr_en;
    logic              trig;
    logic              is_last;
    logic [ADDR_W-1:0] trig_base;

    // Decimation, write pointer, fill count and burst sequencing
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        phase_d      = phase_q;
        fill_cnt_d   = fill_cnt_q;
        pend_d       = pend_q;
        pend_base_d  = pend_base_q;
        rd_addr_d    = rd_addr_q;
        rd_idx_d     = rd_idx_q;
        overrun_d    = overrun_q;
        smpl_out_d   = '0;
        smpl_vld_d   = 1'b0;
        smpl_first_d = 1'b0;
        smpl_last_d  = 1'b0;
        is_last      = 1'b0;

        wr_en     = valid_rise && (phase_q == PH_W'(DECIM - 1));
        trig_base = wr_ptr_q - ADDR_W'(WIN_LEN - 1);

        if (valid_rise) begin
            phase_d = (phase_q == PH_W'(DECIM - 1)) ? '0 : phase_q + PH_W'(1);
        end
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            if (fill_cnt_q != CNT_W'(WIN_LEN)) begin
                fill_cnt_d = fill_cnt_q + CNT_W'(1);
            end
        end
        trig = wr_en && (fill_cnt_d == CNT_W'(WIN_LEN));

        case (state_q)
            S_FILL, S_READY: begin
                if (trig) begin
                    state_d   = S_SEQ;
                    rd_addr_d = trig_base;
                    rd_idx_d  = '0;
                end
            end
            S_SEQ: begin
                is_last      = (rd_idx_q == CNT_W'(WIN_LEN - 1));
                smpl_out_d   = mem[rd_addr_q];
                smpl_vld_d   = 1'b1;
                smpl_first_d = (rd_idx_q == '0);
                smpl_last_d  = is_last;
                rd_addr_d    = rd_addr_q + ADDR_W'(1);
                rd_idx_d     = rd_idx_q + CNT_W'(1);
                // A newer trigger always replaces a still-pending window
                if (trig) begin
                    pend_d      = 1'b1;
                    pend_base_d = trig_base;
                    if (pend_q) begin
                        overrun_d = 1'b1;
                    end
                end
                if (is_last) begin
                    rd_idx_d = '0;
                    if (pend_d) begin
                        rd_addr_d = pend_base_d;
                        pend_d    = 1'b0;
                    end else begin
                        state_d = S_READY;
                    end
                end
            end
            default: state_d = S_FILL;
        endcase

        primed_d     = (state_d != S_FILL);
        sequencing_d = (state_d == S_SEQ) || smpl_vld_d;
    end

    // Sample storage; a flushed or reset cycle drops its sample
    always_ff @(posedge clk) begin
        if (wr_en && !rst && !flush) begin
            mem[wr_ptr_q] <= new_smpl;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state_q      <= S_FILL;
            wr_ptr_q     <= '0;
            phase_q      <= '0;
            fill_cnt_q   <= '0;
            pend_q       <= 1'b0;
            pend_base_q  <= '0;
            rd_addr_q    <= '0;
            rd_idx_q     <= '0;
            overrun_q    <= 1'b0;
            smpl_out_q   <= '0;
            smpl_vld_q   <= 1'b0;
            smpl_first_q <= 1'b0;
            smpl_last_q  <= 1'b0;
            sequencing_q <= 1'b0;
            primed_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            phase_q      <= phase_d;
            fill_cnt_q   <= fill_cnt_d;
            pend_q       <= pend_d;
            pend_base_q  <= pend_base_d;
            rd_addr_q    <= rd_addr_d;
            rd_idx_q     <= rd_idx_d;
            overrun_q    <= overrun_d;
            smpl_out_q   <= smpl_out_d;
            smpl_vld_q   <= smpl_vld_d;
            smpl_first_q <= smpl_first_d;
            smpl_last_q  <= smpl_last_d;
            sequencing_q <= sequencing_d;
            primed_q     <= primed_d;
        end
    end

    assign smpl_out   = smpl_out_q;
    assign smpl_vld   = smpl_vld_q;
    assign smpl_first = smpl_first_q;
    assign smpl_last  = smpl_last_q;
    assign sequencing = sequencing_q;
    assign primed     = primed_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_fir_window_queue.sv
// Directed bench for fir_window_queue: small configs (DECIM=2 and DECIM=1) plus the default
// configuration, all driven from shared inputs; one instance is observed per step.
module tb_fir_window_queue;

    logic        clk = 1'b0;
    logic        rst, flush, valid_rise;
    logic [15:0] new_smpl;

    logic [15:0] so [3];
    logic        vl [3], fi [3], la [3], sq [3], pr [3], ov [3];

    int          sel;
    logic [15:0] cap_d [$];
    bit          cap_f [$];
    bit          cap_l [$];
    int          seq_cyc, rises;
    logic        prev_v;
    int          n_cmp = 0;
    int          n_err = 0;
    int          exp_q [$];

    always #5 clk = ~clk;

    fir_window_queue #(.DATA_W(16), .ADDR_W(4), .WIN_LEN(5), .DECIM(2)) u0 (
        .clk(clk), .rst(rst), .new_smpl(new_smpl), .valid_rise(valid_rise), .flush(flush),
        .smpl_out(so[0]), .smpl_vld(vl[0]), .smpl_first(fi[0]), .smpl_last(la[0]),
        .sequencing(sq[0]), .primed(pr[0]), .overrun(ov[0]));

    fir_window_queue #(.DATA_W(16), .ADDR_W(4), .WIN_LEN(5), .DECIM(1)) u1 (
        .clk(clk), .rst(rst), .new_smpl(new_smpl), .valid_rise(valid_rise), .flush(flush),
        .smpl_out(so[1]), .smpl_vld(vl[1]), .smpl_first(fi[1]), .smpl_last(la[1]),
        .sequencing(sq[1]), .primed(pr[1]), .overrun(ov[1]));

    fir_window_queue u2 (
        .clk(clk), .rst(rst), .new_smpl(new_smpl), .valid_rise(valid_rise), .flush(flush),
        .smpl_out(so[2]), .smpl_vld(vl[2]), .smpl_first(fi[2]), .smpl_last(la[2]),
        .sequencing(sq[2]), .primed(pr[2]), .overrun(ov[2]));

    // Record the observed instance's output stream away from the active edge
    always @(negedge clk) begin
        if (vl[sel] === 1'b1) begin
            cap_d.push_back(so[sel]);
            cap_f.push_back(fi[sel]);
            cap_l.push_back(la[sel]);
        end
        if (sq[sel] === 1'b1) seq_cyc++;
        if (vl[sel] === 1'b1 && prev_v !== 1'b1) rises++;
        prev_v = vl[sel];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic strobe(input int v);
        valid_rise = 1'b1;
        new_smpl   = 16'(v);
        tick();
        valid_rise = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic clr();
        cap_d.delete();
        cap_f.delete();
        cap_l.delete();
        seq_cyc = 0;
        rises   = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Bursts are 5 samples long in the small configs
    task automatic chk_stream(input string tag, input int exp[$]);
        logic [15:0] e;
        chk($sformatf("%s_len", tag), 32'(cap_d.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < cap_d.size(); i++) begin
            e = 16'(exp[i]);
            chk($sformatf("%s_d%0d", tag, i), {16'b0, cap_d[i]}, {16'b0, e});
            chk($sformatf("%s_f%0d", tag, i), 32'(cap_f[i]), 32'((i % 5) == 0));
            chk($sformatf("%s_l%0d", tag, i), 32'(cap_l[i]), 32'((i % 5) == 4));
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; valid_rise = 1'b0; new_smpl = '0;
        sel = 0; prev_v = 1'b0;
        seq_cyc = 0; rises = 0;
        tick();
        tick();
        chk("rst_vld", 32'(vl[0]), 32'd0);
        chk("rst_out", 32'(so[0]), 32'd0);
        chk("rst_primed", 32'(pr[0]), 32'd0);
        chk("rst_ovr", 32'(ov[0]), 32'd0);
        chk("rst_seq", 32'(sq[0]), 32'd0);
        rst = 1'b0;
        clr();

        // Fill: only even samples stored, burst after the 10th strobe
        for (int v = 1; v <= 9; v++) strobe(v);
        chk("fill_primed9", 32'(pr[0]), 32'd0);
        strobe(10);
        chk("fill_primed", 32'(pr[0]), 32'd1);
        chk("fill_vld_t1", 32'(vl[0]), 32'd0);
        chk("fill_seq_t1", 32'(sq[0]), 32'd1);
        tick();
        chk("fill_vld_t2", 32'(vl[0]), 32'd1);
        chk("fill_out_t2", 32'(so[0]), 32'd2);
        chk("fill_first_t2", 32'(fi[0]), 32'd1);
        idle(6);
        chk_stream("fill", '{2, 4, 6, 8, 10});
        chk("fill_seq_cycles", 32'(seq_cyc), 32'd6);

        // Slide: an odd strobe alone stores nothing
        clr();
        strobe(11);
        idle(4);
        chk("slide_odd_none", 32'(cap_d.size()), 32'd0);
        strobe(12);
        idle(8);
        chk_stream("slide", '{4, 6, 8, 10, 12});

        // Pending: trigger during a burst chains seamlessly
        clr();
        for (int v = 13; v <= 16; v++) strobe(v);
        idle(14);
        chk_stream("pend", '{6, 8, 10, 12, 14, 8, 10, 12, 14, 16});
        chk("pend_no_gap", 32'(rises), 32'd1);
        chk("pend_ovr", 32'(ov[0]), 32'd0);

        // Flush, then reset, at the 3rd valid cycle of a burst
        for (int k = 0; k < 2; k++) begin
            do_reset();
            clr();
            for (int v = 1; v <= 10; v++) strobe(v);
            idle(3);
            if (k == 0) flush = 1'b1;
            else        rst   = 1'b1;
            tick();
            flush = 1'b0;
            rst   = 1'b0;
            chk($sformatf("abort%0d_vld", k), 32'(vl[0]), 32'd0);
            chk($sformatf("abort%0d_out", k), 32'(so[0]), 32'd0);
            chk($sformatf("abort%0d_primed", k), 32'(pr[0]), 32'd0);
            chk($sformatf("abort%0d_seq", k), 32'(sq[0]), 32'd0);
            chk($sformatf("abort%0d_cnt", k), 32'(cap_d.size()), 32'd3);
            clr();
            for (int v = 21; v <= 29; v++) strobe(v);
            idle(3);
            chk($sformatf("abort%0d_4wr_none", k), 32'(cap_d.size()), 32'd0);
            chk($sformatf("abort%0d_4wr_primed", k), 32'(pr[0]), 32'd0);
            strobe(30);
            idle(8);
            chk_stream($sformatf("abort%0d_re", k), '{22, 24, 26, 28, 30});
        end

        // Overrun: three triggers inside one burst, DECIM=1
        sel = 1;
        do_reset();
        clr();
        for (int v = 1; v <= 8; v++) strobe(v);
        idle(14);
        chk_stream("ovr", '{1, 2, 3, 4, 5, 4, 5, 6, 7, 8});
        chk("ovr_flag", 32'(ov[1]), 32'd1);

        // Wrap: 40 spaced ramp writes, signed values crossing zero
        do_reset();
        clr();
        exp_q.delete();
        for (int i = 0; i < 40; i++) begin
            strobe(i - 16);
            idle(6);
        end
        idle(4);
        for (int k = 4; k < 40; k++) begin
            for (int j = k - 4; j <= k; j++) exp_q.push_back(j - 16);
        end
        chk_stream("wrap", exp_q);
        chk("wrap_ovr", 32'(ov[1]), 32'd0);

        // Default configuration: one 1021-sample burst of even samples
        sel = 2;
        do_reset();
        clr();
        for (int v = 1; v <= 2042; v++) strobe(v);
        idle(1030);
        chk("dflt_len", 32'(cap_d.size()), 32'd1021);
        chk("dflt_first_val", 32'(cap_d[0]), 32'd2);
        chk("dflt_last_val", 32'(cap_d[$]), 32'd2042);
        chk("dflt_first_flag", 32'(cap_f[0]), 32'd1);
        chk("dflt_last_flag", 32'(cap_l[$]), 32'd1);
        chk("dflt_no_gap", 32'(rises), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
